// File: rtl/logic_reg_pipe.sv
// Runtime-selectable bitwise op (AND/OR/XOR/NAND) on two operands, retimed through
// a DEPTH-stage pipeline with per-stage valid bits, stall, flush and occupancy count.
module logic_reg_pipe #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 3,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    input  logic             IN_VALID,
    input  logic             EN,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic             OUT_VALID,
    output logic [CNTW-1:0]  COUNT
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;

    always_comb begin
        case (OP)
            2'b00:   R = A & B;
            2'b01:   R = A | B;
            2'b10:   R = A ^ B;
            default: R = ~(A & B);
        endcase
    end

    // Flush drops only the valid bits; data stays put whatever EN says.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (FLUSH) begin
            valid_d = '0;
            count_d = '0;
        end else if (EN) begin
            data_d[0]  = R;
            valid_d[0] = IN_VALID;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            count_d = count_q + CNTW'(IN_VALID) - CNTW'(valid_q[DEPTH-1]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign Q         = data_q[DEPTH-1];
    assign OUT_VALID = valid_q[DEPTH-1];
    assign COUNT     = count_q;

endmodule

// File: tb/tb_logic_reg_pipe.sv
// Bench for logic_reg_pipe: a DEPTH=3/WIDTH=8 instance against a queue-based model,
// plus a DEPTH=1/WIDTH=1 instance for the minimum configuration.
module tb_logic_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic       CLK = 1'b0;
    logic       rstN, flush, en, inValid;
    logic [7:0] a, b;
    logic [1:0] op;
    logic [7:0] r, q;
    logic       outValid;
    logic [1:0] count;

    logic       d1RstN, d1A, d1B, d1InValid, d1En, d1Flush;
    logic [1:0] d1Op;
    logic       d1R, d1Q, d1OutValid;
    logic [0:0] d1Count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mData[$];
    bit         mValid[$];

    logic_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(rstN), .A(a), .B(b), .OP(op), .IN_VALID(inValid),
        .EN(en), .FLUSH(flush), .R(r), .Q(q), .OUT_VALID(outValid), .COUNT(count)
    );

    logic_reg_pipe #(.WIDTH(1), .DEPTH(1)) dutMin (
        .CLK(CLK), .RST_N(d1RstN), .A(d1A), .B(d1B), .OP(d1Op), .IN_VALID(d1InValid),
        .EN(d1En), .FLUSH(d1Flush), .R(d1R), .Q(d1Q), .OUT_VALID(d1OutValid), .COUNT(d1Count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] opResult(logic [7:0] x, logic [7:0] y, logic [1:0] o);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // Model: a fixed-length queue, newest entry at the front, Q is the back.
    function automatic void modelReset();
        mData.delete();
        mValid.delete();
        for (int i = 0; i < DEPTH; i++) begin
            mData.push_back(8'h00);
            mValid.push_back(1'b0);
        end
    endfunction

    function automatic void modelEdge();
        if (!rstN) begin
            modelReset();
        end else if (flush) begin
            foreach (mValid[i]) mValid[i] = 1'b0;
        end else if (en) begin
            mData.push_front(opResult(a, b, op));
            mValid.push_front(inValid);
            void'(mData.pop_back());
            void'(mValid.pop_back());
        end
    endfunction

    function automatic logic [1:0] modelCount();
        int n = 0;
        foreach (mValid[i]) n += int'(mValid[i]);
        return 2'(n);
    endfunction

    task automatic clockEdge();
        @(posedge CLK);
        modelEdge();
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; en = 1'b1; flush = 1'b1; inValid = 1'b1;
        clockEdge();
        checks++; if (q !== 8'h00) begin failures++; $display("[TB] FAIL reset_q got=%h exp=%h", q, 8'h00); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_ov got=%b exp=0", outValid); end
        checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        rstN = 1'b1; flush = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); inValid = 1'b1;
            clockEdge();
        end
        checks++; if (count !== 2'd3) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=3", count); end
        checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL fill_ov got=%b exp=1", outValid); end
        rstN = 1'b0;
        #3;
        checks++; if (q !== mData[DEPTH-1]) begin failures++; $display("[TB] FAIL midreset_q got=%h exp=%h", q, mData[DEPTH-1]); end
        checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ov got=%b exp=1", outValid); end
        checks++; if (count !== 2'd3) begin failures++; $display("[TB] FAIL midreset_count got=%0d exp=3", count); end
        clockEdge();
        checks++; if (q !== 8'h00) begin failures++; $display("[TB] FAIL streamreset_q got=%h exp=00", q); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL streamreset_ov got=%b exp=0", outValid); end
        checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL streamreset_count got=%0d exp=0", count); end
        rstN = 1'b1;
    endtask

    task automatic test_opcodes();
        logic [7:0] expR [4] = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
        for (int i = 0; i < 7; i++) begin
            a = 8'hF0; b = 8'h3C; en = 1'b1; flush = 1'b0;
            op = 2'(i); inValid = (i < 4);
            #1;
            if (i < 4) begin
                checks++; if (r !== expR[i]) begin failures++; $display("[TB] FAIL op_r%0d got=%h exp=%h", i, r, expR[i]); end
            end
            clockEdge();
            if (i >= 2 && i < 6) begin
                checks++; if (q !== expR[i-2]) begin failures++; $display("[TB] FAIL op_q%0d got=%h exp=%h", i-2, q, expR[i-2]); end
                checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL op_ov%0d got=%b exp=1", i-2, outValid); end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] res [3];
        en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); inValid = 1'b1;
            res[i] = opResult(a, b, op);
            clockEdge();
        end
        checks++; if (q !== res[0]) begin failures++; $display("[TB] FAIL stall_pre_q got=%h exp=%h", q, res[0]); end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); inValid = 1'b1;
            clockEdge();
            checks++; if (q !== res[0]) begin failures++; $display("[TB] FAIL stall_q%0d got=%h exp=%h", i, q, res[0]); end
            checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL stall_ov%0d got=%b exp=1", i, outValid); end
            checks++; if (count !== 2'd3) begin failures++; $display("[TB] FAIL stall_count%0d got=%0d exp=3", i, count); end
        end
        en = 1'b1; inValid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            clockEdge();
            checks++; if (q !== res[k]) begin failures++; $display("[TB] FAIL resume_q%0d got=%h exp=%h", k, q, res[k]); end
            checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL resume_ov%0d got=%b exp=1", k, outValid); end
        end
    endtask

    task automatic test_sparse();
        bit         pat      [6] = '{1, 0, 1, 0, 0, 0};
        logic [1:0] expCount [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
        bit         expOv    [6] = '{0, 0, 1, 0, 1, 0};
        rstN = 1'b0; clockEdge(); rstN = 1'b1;
        en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); inValid = pat[i];
            clockEdge();
            checks++; if (count !== expCount[i]) begin failures++; $display("[TB] FAIL sparse_count%0d got=%0d exp=%0d", i, count, expCount[i]); end
            checks++; if (outValid !== expOv[i]) begin failures++; $display("[TB] FAIL sparse_ov%0d got=%b exp=%b", i, outValid, expOv[i]); end
            if (expOv[i]) begin
                checks++; if (q !== mData[DEPTH-1]) begin failures++; $display("[TB] FAIL sparse_q%0d got=%h exp=%h", i, q, mData[DEPTH-1]); end
            end
        end
    endtask

    task automatic test_flush();
        en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); inValid = 1'b1;
            clockEdge();
        end
        checks++; if (count !== 2'd3) begin failures++; $display("[TB] FAIL full_count got=%0d exp=3", count); end
        checks++; if (q !== mData[DEPTH-1]) begin failures++; $display("[TB] FAIL full_stream_q got=%h exp=%h", q, mData[DEPTH-1]); end
        flush = 1'b1; inValid = 1'b1;
        clockEdge();
        checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_ov got=%b exp=0", outValid); end
        flush = 1'b0; inValid = 1'b0;
        clockEdge();
        checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL postflush_count got=%0d exp=0", count); end
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); inValid = 1'b1;
            clockEdge();
        end
        en = 1'b0; flush = 1'b1;
        clockEdge();
        checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL stallflush_count got=%0d exp=0", count); end
        en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'hFF; b = 8'h5A; op = 2'b01; inValid = 1'b1;
            clockEdge();
        end
        flush = 1'b1; rstN = 1'b0;
        clockEdge();
        checks++; if (q !== 8'h00) begin failures++; $display("[TB] FAIL flushreset_q got=%h exp=00", q); end
        checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL flushreset_count got=%0d exp=0", count); end
        flush = 1'b0; rstN = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rstN    = ($urandom_range(0, 49) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            en      = ($urandom_range(0, 3) != 0);
            inValid = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            #1;
            checks++; if (r !== opResult(a, b, op)) begin failures++; $display("[TB] FAIL rand_r%0d got=%h exp=%h", i, r, opResult(a, b, op)); end
            clockEdge();
            checks++; if (outValid !== mValid[DEPTH-1]) begin failures++; $display("[TB] FAIL rand_ov%0d got=%b exp=%b", i, outValid, mValid[DEPTH-1]); end
            checks++; if (count !== modelCount()) begin failures++; $display("[TB] FAIL rand_count%0d got=%0d exp=%0d", i, count, modelCount()); end
            if (mValid[DEPTH-1]) begin
                checks++; if (q !== mData[DEPTH-1]) begin failures++; $display("[TB] FAIL rand_q%0d got=%h exp=%h", i, q, mData[DEPTH-1]); end
            end
        end
        rstN = 1'b1; flush = 1'b0;
    endtask

    task automatic test_min_depth();
        d1RstN = 1'b0;
        @(posedge CLK); #1;
        checks++; if (d1Q !== 1'b0 || d1OutValid !== 1'b0 || d1Count !== 1'b0) begin
            failures++; $display("[TB] FAIL min_reset got=%b%b%b exp=000", d1Q, d1OutValid, d1Count);
        end
        d1RstN = 1'b1; d1A = 1'b1; d1B = 1'b1; d1Op = 2'b00; d1InValid = 1'b1; d1En = 1'b1; d1Flush = 1'b0;
        #1;
        checks++; if (d1R !== 1'b1) begin failures++; $display("[TB] FAIL min_r got=%b exp=1", d1R); end
        @(posedge CLK); #1;
        checks++; if (d1Q !== 1'b1) begin failures++; $display("[TB] FAIL min_q got=%b exp=1", d1Q); end
        checks++; if (d1OutValid !== 1'b1 || d1Count !== 1'b1) begin
            failures++; $display("[TB] FAIL min_valid got=%b/%b exp=1/1", d1OutValid, d1Count);
        end
        d1A = 1'b0;
        @(posedge CLK); #1;
        checks++; if (d1Q !== 1'b0) begin failures++; $display("[TB] FAIL min_q_and0 got=%b exp=0", d1Q); end
        d1InValid = 1'b0;
        @(posedge CLK); #1;
        checks++; if (d1OutValid !== 1'b0 || d1Count !== 1'b0) begin
            failures++; $display("[TB] FAIL min_drain got=%b/%b exp=0/0", d1OutValid, d1Count);
        end
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; en = 1'b0; inValid = 1'b0;
        a = 8'h00; b = 8'h00; op = 2'b00;
        d1RstN = 1'b0; d1A = 1'b0; d1B = 1'b0; d1Op = 2'b00;
        d1InValid = 1'b0; d1En = 1'b0; d1Flush = 1'b0;
        modelReset();
        #1;
        test_reset();
        test_opcodes();
        test_stall();
        test_sparse();
        test_flush();
        test_random();
        en = 1'b0;
        test_min_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
